// File: rtl/regbank_wport_arbiter_pkg.sv
// Shared CPU constants for the Regbank write-port arbiter and its scoreboard.
package regbank_wport_arbiter_pkg;
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned NUM_REGS   = 16;
    localparam int unsigned CNT_W      = 4;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    // One Regbank write-port transaction.
    typedef struct packed {
        logic      we;
        reg_addr_t addr;
        reg_data_t data;
    } rf_wr_t;
endpackage

// File: rtl/regbank_wport_arbiter_if.sv
// WB/MU/ID-side signals and the Regbank write port around the arbiter.
interface regbank_wport_arbiter_if import regbank_wport_arbiter_pkg::*; ();
    logic      wb_we;
    reg_addr_t wb_addr;
    reg_data_t wb_data;
    logic      mu_valid;
    reg_addr_t mu_addr;
    reg_data_t mu_data;
    logic      mu_ready;
    logic      issue_valid;
    reg_addr_t issue_addr;
    reg_addr_t rd_addr_a;
    reg_addr_t rd_addr_b;
    logic      rf_we;
    reg_addr_t rf_addr_d;
    reg_data_t rf_data_d;
    logic      raw_stall;
    logic      issue_stall;
    logic      starve_hold;

    // Arbiter side.
    modport slave (
        input  wb_we, wb_addr, wb_data, mu_valid, mu_addr, mu_data,
               issue_valid, issue_addr, rd_addr_a, rd_addr_b,
        output mu_ready, rf_we, rf_addr_d, rf_data_d,
               raw_stall, issue_stall, starve_hold
    );

    // Pipeline / MU / Regbank side.
    modport master (
        output wb_we, wb_addr, wb_data, mu_valid, mu_addr, mu_data,
               issue_valid, issue_addr, rd_addr_a, rd_addr_b,
        input  mu_ready, rf_we, rf_addr_d, rf_data_d,
               raw_stall, issue_stall, starve_hold
    );
endinterface

// File: rtl/regbank_wport_arbiter_scoreboard.sv
// Busy bitmap of registers awaiting an MU result; r0 is never busy.
module regbank_scoreboard
    import regbank_wport_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      issue_valid_i,
    input  reg_addr_t issue_addr_i,
    input  logic      clr_en_i,
    input  reg_addr_t clr_addr_i,
    input  reg_addr_t rd_addr_a_i,
    input  reg_addr_t rd_addr_b_i,
    output logic      raw_stall_o,
    output logic      issue_stall_o
);
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                set_en;

    // Lookups use registered busy only, so a commit still stalls its consumer once.
    always_comb begin
        raw_stall_o   = ((rd_addr_a_i != REG_ZERO) && busy_q[rd_addr_a_i]) ||
                        ((rd_addr_b_i != REG_ZERO) && busy_q[rd_addr_b_i]);
        issue_stall_o = issue_valid_i && (issue_addr_i != REG_ZERO) && busy_q[issue_addr_i];
        set_en        = issue_valid_i && !issue_stall_o && (issue_addr_i != REG_ZERO);
    end

    // Clear first, then set, so a same-cycle set on the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
        if (set_en)   busy_d[issue_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Busy bitmap register.
    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end
endmodule

// File: rtl/regbank_wport_arbiter.sv
// Regbank write-port arbiter: WB has fixed priority, a starvation counter
// forces a one-cycle pipeline hold so the MU result always lands.
module regbank_wport_arbiter
    import regbank_wport_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    regbank_wport_arbiter_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    logic             starve_hold_q, starve_hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wb_act, mu_ready, mu_commit, mu_blocked;
    rf_wr_t           wr;

    // Grant: WB wins unless it targets r0 or the pipeline is being held.
    always_comb begin
        wb_act     = bus.wb_we && (bus.wb_addr != REG_ZERO) && !starve_hold_q;
        mu_ready   = bus.mu_valid && !wb_act;
        mu_commit  = bus.mu_valid && mu_ready;
        mu_blocked = bus.mu_valid && !mu_ready;
    end

    // Write-port mux; idle port drives zeros.
    always_comb begin
        wr = '0;
        if (wb_act) begin
            wr.we   = 1'b1;
            wr.addr = bus.wb_addr;
            wr.data = bus.wb_data;
        end else if (mu_commit) begin
            wr.we   = (bus.mu_addr != REG_ZERO);
            wr.addr = bus.mu_addr;
            wr.data = bus.mu_data;
        end
    end

    // Starvation tracking: the hold fires on the LIMIT-th consecutive blocked cycle.
    always_comb begin
        cnt_d         = mu_blocked ? cnt_q + CNT_W'(1) : '0;
        starve_hold_d = mu_blocked && (cnt_q == CNT_LAST);
    end

    // Counter and hold registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            starve_hold_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            starve_hold_q <= starve_hold_d;
        end
    end

    regbank_scoreboard u_sb (
        .clk           (clk),
        .reset         (reset),
        .issue_valid_i (bus.issue_valid),
        .issue_addr_i  (bus.issue_addr),
        .clr_en_i      (mu_commit),
        .clr_addr_i    (bus.mu_addr),
        .rd_addr_a_i   (bus.rd_addr_a),
        .rd_addr_b_i   (bus.rd_addr_b),
        .raw_stall_o   (bus.raw_stall),
        .issue_stall_o (bus.issue_stall)
    );

    assign bus.mu_ready    = mu_ready;
    assign bus.rf_we       = wr.we;
    assign bus.rf_addr_d   = wr.addr;
    assign bus.rf_data_d   = wr.data;
    assign bus.starve_hold = starve_hold_q;
endmodule

// File: tb/tb_regbank_wport_arbiter.sv
// Directed-vector bench for regbank_wport_arbiter with an expected-response queue.
module tb_regbank_wport_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;

    regbank_wport_arbiter_if bus ();

    regbank_wport_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        mr;
        logic        we;
        logic [3:0]  a;
        logic [31:0] d;
        logic        raw;
        logic        iss;
        logic        hold;
    } exp_t;

    exp_t expq[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s.%s got %h expected %h", nm, fld, got, exp);
        end
    endtask

    // Monitor: outputs are combinational, so every driven cycle presents one response.
    always @(negedge clk) begin
        if (expq.size() != 0) begin
            exp_t e;
            e = expq.pop_front();
            chk(e.name, "mu_ready",    {31'd0, bus.mu_ready},    {31'd0, e.mr});
            chk(e.name, "rf_we",       {31'd0, bus.rf_we},       {31'd0, e.we});
            chk(e.name, "rf_addr_d",   {28'd0, bus.rf_addr_d},   {28'd0, e.a});
            chk(e.name, "rf_data_d",   bus.rf_data_d,            e.d);
            chk(e.name, "raw_stall",   {31'd0, bus.raw_stall},   {31'd0, e.raw});
            chk(e.name, "issue_stall", {31'd0, bus.issue_stall}, {31'd0, e.iss});
            chk(e.name, "starve_hold", {31'd0, bus.starve_hold}, {31'd0, e.hold});
        end
    end

    // One cycle: apply inputs just after the edge and queue the expected response.
    task automatic cyc(
        input string nm, input logic rst,
        input logic we, input logic [3:0] wa, input logic [31:0] wd,
        input logic mv, input logic [3:0] ma, input logic [31:0] md,
        input logic iv, input logic [3:0] ia, input logic [3:0] ra, input logic [3:0] rb,
        input logic e_mr, input logic e_we, input logic [3:0] e_a, input logic [31:0] e_d,
        input logic e_raw, input logic e_is, input logic e_h);
        exp_t e;
        @(posedge clk);
        #1;
        reset           = rst;
        bus.wb_we       = we;  bus.wb_addr  = wa; bus.wb_data = wd;
        bus.mu_valid    = mv;  bus.mu_addr  = ma; bus.mu_data = md;
        bus.issue_valid = iv;  bus.issue_addr = ia;
        bus.rd_addr_a   = ra;  bus.rd_addr_b  = rb;
        e.name = nm; e.mr = e_mr; e.we = e_we; e.a = e_a; e.d = e_d;
        e.raw = e_raw; e.iss = e_is; e.hold = e_h;
        expq.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] WD = 32'h1111_0001;
    localparam logic [31:0] MD = 32'h0000_0099;

    initial begin
        bus.wb_we = 0; bus.wb_addr = 0; bus.wb_data = 0;
        bus.mu_valid = 0; bus.mu_addr = 0; bus.mu_data = 0;
        bus.issue_valid = 0; bus.issue_addr = 0;
        bus.rd_addr_a = 0; bus.rd_addr_b = 0;
        @(posedge clk);
        //   name        rst we wa   wd            mv ma   md            iv ia   ra   rb     mr we a    d             raw is h
        cyc("reset",      1, 0, 0,   0,            0, 0,   0,            0, 0,   0,   0,     0, 0, 0,   0,            0, 0, 0);
        cyc("wb_only",    0, 1, 5,   32'h1234,     0, 0,   0,            0, 0,   0,   0,     0, 1, 5,   32'h1234,     0, 0, 0);
        cyc("conflict",   0, 1, 3,   32'hAAAA0003, 1, 7,   32'h77,       0, 0,   0,   0,     0, 1, 3,   32'hAAAA0003, 0, 0, 0);
        cyc("mu_after",   0, 0, 3,   32'hAAAA0003, 1, 7,   32'h77,       0, 0,   0,   0,     1, 1, 7,   32'h77,       0, 0, 0);
        cyc("wb_r0",      0, 1, 0,   32'hDEAD,     1, 2,   32'h22,       0, 0,   0,   0,     1, 1, 2,   32'h22,       0, 0, 0);
        cyc("both_r0",    0, 1, 0,   32'hDEAD,     1, 0,   32'h55,       0, 0,   0,   0,     1, 0, 0,   32'h55,       0, 0, 0);
        cyc("idle",       0, 0, 0,   0,            0, 0,   0,            0, 0,   0,   0,     0, 0, 0,   0,            0, 0, 0);
        // Continuous WB to r1 starves MU to r9.
        for (int k = 0; k < 4; k++)
            cyc("starve_blk", 0, 1, 1, WD,         1, 9,   MD,           0, 0,   0,   0,     0, 1, 1,   WD,           0, 0, 0);
        cyc("starve_hold",0, 1, 1,   WD,           1, 9,   MD,           0, 0,   0,   0,     1, 1, 9,   MD,           0, 0, 1);
        cyc("starve_end", 0, 1, 1,   WD,           0, 9,   MD,           0, 0,   0,   0,     0, 1, 1,   WD,           0, 0, 0);
        // Scoreboard.
        cyc("issue6",     0, 0, 0,   0,            0, 0,   0,            1, 6,   0,   0,     0, 0, 0,   0,            0, 0, 0);
        cyc("raw6_waw6",  0, 0, 0,   0,            0, 0,   0,            1, 6,   6,   0,     0, 0, 0,   0,            1, 1, 0);
        cyc("commit6",    0, 0, 0,   0,            1, 6,   32'h66,       0, 0,   6,   0,     1, 1, 6,   32'h66,       1, 0, 0);
        cyc("after_c6",   0, 0, 0,   0,            0, 0,   0,            0, 0,   6,   6,     0, 0, 0,   0,            0, 0, 0);
        cyc("iss_r0",     0, 0, 0,   0,            0, 0,   0,            1, 0,   0,   0,     0, 0, 0,   0,            0, 0, 0);
        cyc("r0_notbusy", 0, 0, 0,   0,            0, 0,   0,            1, 0,   0,   0,     0, 0, 0,   0,            0, 0, 0);
        cyc("set_clr6",   0, 0, 0,   0,            1, 6,   32'h6A,       1, 6,   0,   6,     1, 1, 6,   32'h6A,       0, 0, 0);
        cyc("set_wins",   0, 0, 0,   0,            0, 0,   0,            1, 6,   0,   6,     0, 0, 0,   0,            1, 1, 0);
        // Build busy={r4,r8} and cnt=2, then reset.
        cyc("pre_r4",     0, 1, 1,   WD,           1, 11,  32'hB,        1, 4,   0,   0,     0, 1, 1,   WD,           0, 0, 0);
        cyc("pre_r8",     0, 1, 1,   WD,           1, 11,  32'hB,        1, 8,   0,   0,     0, 1, 1,   WD,           0, 0, 0);
        cyc("rst_mid",    1, 0, 0,   0,            0, 0,   0,            0, 0,   4,   8,     0, 0, 0,   0,            1, 0, 0);
        cyc("post_rst",   0, 1, 1,   WD,           1, 11,  32'hB,        0, 0,   4,   8,     0, 1, 1,   WD,           0, 0, 0);
        for (int k = 0; k < 3; k++)
            cyc("post_blk",   0, 1, 1, WD,         1, 11,  32'hB,        0, 0,   6,   0,     0, 1, 1,   WD,           0, 0, 0);
        cyc("post_hold",  0, 1, 1,   WD,           1, 11,  32'hB,        0, 0,   0,   0,     1, 1, 11,  32'hB,        0, 0, 1);
        cyc("post_end",   0, 0, 0,   0,            0, 0,   0,            0, 0,   0,   0,     0, 0, 0,   0,            0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
